// File: rtl/eb_serializer.sv
// eb_serializer: wide-to-narrow stream serializer on the valid/ready handshake.
// Accepts one word of RATIO slices on the target side and emits 1..RATIO of
// those slices as narrow beats on the initiator side, flagging the final beat.
// A new word is accepted in the same cycle the previous word's last beat is
// consumed, so back-to-back words stream without a bubble.
// t_ready depends combinationally on i_ready; downstream must not derive
// i_ready from t_ready.
module eb_serializer #(
  parameter int DWIDTH    = 32,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DWIDTH*RATIO-1:0]   t_data,
  input  logic [$clog2(RATIO):0]    t_nbeats,
  input  logic                      t_valid,
  output logic                      t_ready,
  output logic [DWIDTH-1:0]         i_data,
  output logic                      i_last,
  output logic                      i_valid,
  input  logic                      i_ready,
  output logic                      busy
);

  localparam int IDXW = $clog2(RATIO);
  localparam int NBW  = IDXW + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [NBW-1:0]                nb_q, nb_d;
  logic [RATIO-1:0][DWIDTH-1:0]  wreg_q, wreg_d;
  logic [IDXW-1:0]               slice_sel;
  logic                          last_beat;
  logic                          t_ready_c;

  // A requested beat count of 0 or above RATIO means "the whole word".
  function automatic logic [NBW-1:0] norm_nbeats(input logic [NBW-1:0] n);
    if (n == '0 || n > NBW'(RATIO)) return NBW'(RATIO);
    return n;
  endfunction

  // Final beat of the held word; only meaningful while a word is held.
  assign last_beat = (state_q == SEND) && ({1'b0, idx_q} == nb_q - NBW'(1));

  // Map the beat index onto a slice of the held word.
  assign slice_sel = (MSB_FIRST != 0) ? IDXW'(RATIO - 1) - idx_q : idx_q;

  assign i_data  = wreg_q[slice_sel];
  assign i_last  = last_beat;
  assign busy    = i_valid;
  // t_ready is held low while reset is asserted so no word is taken then.
  assign t_ready = t_ready_c & ~rst;

  // Next-state, capture and handshake logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nb_d      = nb_q;
    wreg_d    = wreg_q;
    i_valid   = 1'b0;
    t_ready_c = 1'b0;
    unique case (state_q)
      EMPTY: begin
        t_ready_c = 1'b1;
        if (t_valid) begin
          state_d = SEND;
          wreg_d  = t_data;
          nb_d    = norm_nbeats(t_nbeats);
          idx_d   = '0;
        end
      end
      SEND: begin
        i_valid   = 1'b1;
        t_ready_c = last_beat & i_ready;
        if (i_ready) begin
          if (!last_beat) begin
            idx_d = idx_q + IDXW'(1);
          end else if (t_valid) begin
            // Refill in the same cycle the last beat leaves: no bubble.
            wreg_d = t_data;
            nb_d   = norm_nbeats(t_nbeats);
            idx_d  = '0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers with synchronous active-high reset.
  // NOTE: the word register is reset too, so i_data reads zero after reset
  // and no stale slice of a discarded word can ever reappear.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register update in step
      // with the clock edge, independent of statement order.
      state_q <= EMPTY;
      idx_q   <= '0;
      nb_q    <= NBW'(RATIO);
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nb_q    <= nb_d;
      wreg_q  <= wreg_d;
    end
  end

endmodule

// File: tb/tb_eb_serializer.sv
// tb_eb_serializer: directed self-checking bench for eb_serializer.
// Main instance: DWIDTH=8, RATIO=4, LSB-first. A second instance with
// MSB_FIRST=1 covers the reversed slice order.
module tb_eb_serializer;

  localparam int DW = 8;
  localparam int R  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic [31:0]   t_data   = '0;
  logic [2:0]    t_nbeats = '0;
  logic          t_valid  = 1'b0;
  logic          t_ready;
  logic [7:0]    i_data;
  logic          i_last;
  logic          i_valid;
  logic          i_ready  = 1'b0;
  logic          busy;

  logic [31:0]   m_t_data   = '0;
  logic [2:0]    m_t_nbeats = '0;
  logic          m_t_valid  = 1'b0;
  logic          m_t_ready;
  logic [7:0]    m_i_data;
  logic          m_i_last;
  logic          m_i_valid;
  logic          m_i_ready  = 1'b0;
  logic          m_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eb_serializer #(.DWIDTH(DW), .RATIO(R), .MSB_FIRST(0)) dut (
    .clk(clk), .rst(rst),
    .t_data(t_data), .t_nbeats(t_nbeats), .t_valid(t_valid), .t_ready(t_ready),
    .i_data(i_data), .i_last(i_last), .i_valid(i_valid), .i_ready(i_ready),
    .busy(busy)
  );

  eb_serializer #(.DWIDTH(DW), .RATIO(R), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst),
    .t_data(m_t_data), .t_nbeats(m_t_nbeats), .t_valid(m_t_valid), .t_ready(m_t_ready),
    .i_data(m_i_data), .i_last(m_i_last), .i_valid(m_i_valid), .i_ready(m_i_ready),
    .busy(m_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic l, input logic tr);
    check({tag, ".valid"}, i_valid, 1'b1);
    check({tag, ".busy"}, busy, 1'b1);
    check({tag, ".data"}, i_data, d);
    check({tag, ".last"}, i_last, l);
    check({tag, ".t_ready"}, t_ready, tr);
  endtask

  task automatic idle(input string tag);
    check({tag, ".valid"}, i_valid, 1'b0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".last"}, i_last, 1'b0);
    check({tag, ".t_ready"}, t_ready, 1'b1);
  endtask

  initial begin
    // Reset state, held over two edges.
    tick();
    tick();
    check("rst.t_ready", t_ready, 1'b0);
    check("rst.valid", i_valid, 1'b0);
    check("rst.last", i_last, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.data", i_data, 8'h00);
    rst = 1'b0;
    settle();
    idle("post_rst");

    // One full word, LSB first, no backpressure.
    i_ready = 1'b1;
    t_data = 32'hDDCCBBAA; t_nbeats = 3'd4; t_valid = 1'b1;
    settle();
    check("w1.accept_ready", t_ready, 1'b1);
    tick(); t_valid = 1'b0; settle();
    beat("w1.b0", 8'hAA, 1'b0, 1'b0);
    tick(); beat("w1.b1", 8'hBB, 1'b0, 1'b0);
    tick(); beat("w1.b2", 8'hCC, 1'b0, 1'b0);
    tick(); beat("w1.b3", 8'hDD, 1'b1, 1'b1);
    tick(); idle("w1.done");

    // Back-to-back words with t_valid held high: eight beats, no bubble.
    t_data = 32'h04030201; t_nbeats = 3'd4; t_valid = 1'b1;
    tick(); t_data = 32'h08070605; settle();
    beat("b2b.b0", 8'h01, 1'b0, 1'b0);
    tick(); beat("b2b.b1", 8'h02, 1'b0, 1'b0);
    tick(); beat("b2b.b2", 8'h03, 1'b0, 1'b0);
    tick(); beat("b2b.b3", 8'h04, 1'b1, 1'b1);
    tick(); t_valid = 1'b0; settle();
    beat("b2b.b4", 8'h05, 1'b0, 1'b0);
    tick(); beat("b2b.b5", 8'h06, 1'b0, 1'b0);
    tick(); beat("b2b.b6", 8'h07, 1'b0, 1'b0);
    tick(); beat("b2b.b7", 8'h08, 1'b1, 1'b1);
    tick(); idle("b2b.done");

    // Backpressure on beat 2 for three cycles.
    t_data = 32'hDDCCBBAA; t_nbeats = 3'd4; t_valid = 1'b1;
    tick(); t_valid = 1'b0; settle();
    beat("bp.b0", 8'hAA, 1'b0, 1'b0);
    tick(); beat("bp.b1", 8'hBB, 1'b0, 1'b0);
    tick(); i_ready = 1'b0; settle();
    beat("bp.hold1", 8'hCC, 1'b0, 1'b0);
    tick(); beat("bp.hold2", 8'hCC, 1'b0, 1'b0);
    tick(); beat("bp.hold3", 8'hCC, 1'b0, 1'b0);
    tick(); i_ready = 1'b1; settle();
    beat("bp.b2", 8'hCC, 1'b0, 1'b0);
    tick(); i_ready = 1'b0; settle();
    beat("bp.last_stall", 8'hDD, 1'b1, 1'b0);
    i_ready = 1'b1; settle();
    beat("bp.b3", 8'hDD, 1'b1, 1'b1);
    tick(); idle("bp.done");

    // Stream of one-beat words: one word per cycle, every beat last.
    t_data = 32'h00000011; t_nbeats = 3'd1; t_valid = 1'b1;
    tick(); t_data = 32'h00000022; settle();
    beat("nb1.w0", 8'h11, 1'b1, 1'b1);
    tick(); t_data = 32'h00000033; settle();
    beat("nb1.w1", 8'h22, 1'b1, 1'b1);
    tick(); t_valid = 1'b0; settle();
    beat("nb1.w2", 8'h33, 1'b1, 1'b1);
    tick(); idle("nb1.done");

    // t_nbeats = 0 means the whole word.
    t_data = 32'h4D3C2B1A; t_nbeats = 3'd0; t_valid = 1'b1;
    tick(); t_valid = 1'b0; settle();
    beat("nb0.b0", 8'h1A, 1'b0, 1'b0);
    tick(); beat("nb0.b1", 8'h2B, 1'b0, 1'b0);
    tick(); beat("nb0.b2", 8'h3C, 1'b0, 1'b0);
    tick(); beat("nb0.b3", 8'h4D, 1'b1, 1'b1);
    tick(); idle("nb0.done");

    // t_nbeats = 7 (above RATIO) also means the whole word.
    t_data = 32'h88776655; t_nbeats = 3'd7; t_valid = 1'b1;
    tick(); t_valid = 1'b0; settle();
    beat("nb7.b0", 8'h55, 1'b0, 1'b0);
    tick(); beat("nb7.b1", 8'h66, 1'b0, 1'b0);
    tick(); beat("nb7.b2", 8'h77, 1'b0, 1'b0);
    tick(); beat("nb7.b3", 8'h88, 1'b1, 1'b1);
    tick(); idle("nb7.done");

    // Reset after beat BB discards the rest of the word.
    t_data = 32'hDDCCBBAA; t_nbeats = 3'd4; t_valid = 1'b1;
    tick(); t_valid = 1'b0; settle();
    beat("mr.b0", 8'hAA, 1'b0, 1'b0);
    tick(); beat("mr.b1", 8'hBB, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("mr.rst_valid", i_valid, 1'b0);
    check("mr.rst_data", i_data, 8'h00);
    check("mr.rst_last", i_last, 1'b0);
    check("mr.rst_t_ready", t_ready, 1'b0);
    rst = 1'b0;
    t_data = 32'h0F0E0D0C; t_nbeats = 3'd4; t_valid = 1'b1;
    tick(); t_valid = 1'b0; settle();
    beat("mr.n0", 8'h0C, 1'b0, 1'b0);
    tick(); beat("mr.n1", 8'h0D, 1'b0, 1'b0);
    tick(); beat("mr.n2", 8'h0E, 1'b0, 1'b0);
    tick(); beat("mr.n3", 8'h0F, 1'b1, 1'b1);
    tick(); idle("mr.done");

    // MSB-first instance, two beats from the top of the word.
    m_i_ready = 1'b1;
    m_t_data = 32'hDDCCBBAA; m_t_nbeats = 3'd2; m_t_valid = 1'b1;
    settle();
    check("msb.accept_ready", m_t_ready, 1'b1);
    tick(); m_t_valid = 1'b0; settle();
    check("msb.b0.valid", m_i_valid, 1'b1);
    check("msb.b0.data", m_i_data, 8'hDD);
    check("msb.b0.last", m_i_last, 1'b0);
    check("msb.b0.t_ready", m_t_ready, 1'b0);
    tick();
    check("msb.b1.valid", m_i_valid, 1'b1);
    check("msb.b1.data", m_i_data, 8'hCC);
    check("msb.b1.last", m_i_last, 1'b1);
    check("msb.b1.t_ready", m_t_ready, 1'b1);
    tick();
    check("msb.done.valid", m_i_valid, 1'b0);
    check("msb.done.busy", m_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
